// File: rtl/sio_bus_master.sv
// -----------------------------------------------------------------------------
// sio_bus_master
//   Bus-side initiator for the simple serial I/O peripheral. It polls the
//   peripheral status register, drains received bytes into an RX FIFO and
//   feeds bytes from a TX FIFO into the peripheral data register. The fabric
//   side sees two plain valid/ready byte streams.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   sio_ce/rd/wr/cd      registered peripheral strobes (cd=1 selects status)
//   sio_dout [7:0]       write data, holds its last written value
//   sio_din  [7:0]       read data, valid the cycle after a read strobe
//   tx_data/valid/ready  TX byte push stream (ready = TX FIFO not full)
//   rx_data/valid/ready  RX byte pop stream (data = RX FIFO head)
//
// Parameters
//   FIFO_DEPTH  entries per FIFO, power of two, >= 2
//   POLL_GAP    idle cycles between bus transactions, >= 1
// -----------------------------------------------------------------------------

// Byte FIFO. Pointers carry one extra wrap bit so that full and empty are
// distinguishable without a separate count.
module sio_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    // Full/empty come from the registered pointers only, so a pop in the
    // same cycle never makes room for a push to a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module sio_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       sio_ce,
    output logic       sio_rd,
    output logic       sio_wr,
    output logic       sio_cd,
    output logic [7:0] sio_dout,
    input  logic [7:0] sio_din,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready
);
    localparam logic [2:0] S_GAP      = 3'd0;
    localparam logic [2:0] S_STAT_RD  = 3'd1;
    localparam logic [2:0] S_STAT_CAP = 3'd2;
    localparam logic [2:0] S_DATA_RD  = 3'd3;
    localparam logic [2:0] S_DATA_CAP = 3'd4;
    localparam logic [2:0] S_DATA_WR  = 3'd5;

    // Gap counter holds the remaining GAP cycles minus one.
    localparam int            GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          ce_q, ce_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          cd_q, cd_d;
    logic [7:0]    dout_q, dout_d;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic          rx_push, rx_pop, rx_full, rx_empty;

    sio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (sio_din),
        .pop       (rx_pop),
        .head      (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Ready is held low during reset so nothing is accepted into a FIFO
    // that is being cleared.
    assign tx_ready = !rst && !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_ready;

    // Poll sequencer. The status byte is decoded straight off sio_din in the
    // capture cycle so the branch costs no extra cycle. RX wins over TX: the
    // peripheral drops new serial data while its RX byte is unread. A full RX
    // FIFO leaves the byte in the peripheral as backpressure.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state_q)
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_STAT_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            S_STAT_RD: begin
                state_d = S_STAT_CAP;
            end
            S_STAT_CAP: begin
                if (sio_din[1] && !rx_full) begin
                    state_d = S_DATA_RD;
                end else if (sio_din[0] && !tx_empty) begin
                    state_d = S_DATA_WR;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            S_DATA_RD: begin
                state_d = S_DATA_CAP;
            end
            S_DATA_CAP: begin
                rx_push   = 1'b1;
                state_d   = S_GAP;
                gap_cnt_d = GAP_LOAD;
            end
            S_DATA_WR: begin
                // The head was presented on sio_dout for this strobe.
                tx_pop    = 1'b1;
                state_d   = S_GAP;
                gap_cnt_d = GAP_LOAD;
            end
            default: begin
                state_d   = S_GAP;
                gap_cnt_d = GAP_LOAD;
            end
        endcase
    end

    // Strobes are decoded from the next state and registered, so each bus
    // output is a flop that is high exactly while the FSM sits in the
    // matching transaction state.
    always_comb begin
        ce_d   = (state_d == S_STAT_RD) || (state_d == S_DATA_RD) ||
                 (state_d == S_DATA_WR);
        rd_d   = (state_d == S_STAT_RD) || (state_d == S_DATA_RD);
        wr_d   = (state_d == S_DATA_WR);
        cd_d   = (state_d == S_STAT_RD);
        dout_d = (state_d == S_DATA_WR) ? tx_head : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_GAP;
            gap_cnt_q <= GAP_LOAD;
            ce_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cd_q      <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ce_q      <= ce_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cd_q      <= cd_d;
            dout_q    <= dout_d;
        end
    end

    assign sio_ce   = ce_q;
    assign sio_rd   = rd_q;
    assign sio_wr   = wr_q;
    assign sio_cd   = cd_q;
    assign sio_dout = dout_q;
endmodule

// File: tb/tb_sio_bus_master.sv
`timescale 1ns/1ps
// Directed bench for sio_bus_master with a small peripheral model: status
// byte = {6'b0, rx byte pending, tx idle}; data reads pop the pending queue.
module tb_sio_bus_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       sio_ce, sio_rd, sio_wr, sio_cd;
    logic [7:0] sio_dout;
    logic [7:0] sio_din;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    always #5 clk = ~clk;

    sio_bus_master #(.FIFO_DEPTH(4), .POLL_GAP(1)) dut (
        .clk(clk), .rst(rst),
        .sio_ce(sio_ce), .sio_rd(sio_rd), .sio_wr(sio_wr), .sio_cd(sio_cd),
        .sio_dout(sio_dout), .sio_din(sio_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // Peripheral model
    logic       m_txidle = 1'b0;
    logic [7:0] m_din = 8'h00;
    logic [7:0] rxq[$];
    assign sio_din = m_din;

    always @(posedge clk) begin
        if (sio_ce && sio_rd) begin
            if (sio_cd) m_din <= {6'b0, (rxq.size() != 0), m_txidle};
            else if (rxq.size() != 0) m_din <= rxq.pop_front();
        end
    end

    // Bus monitor, sampled on the falling edge
    int         cyc = 0;
    int         stat_n = 0, rd_n = 0, wr_n = 0, both_err = 0;
    int         last_stat_cyc = 0, last_period = 0;
    int         rd_gap = 0, rd_stat = 0, wr_gap = 0, wr_stat = 0;
    logic [7:0] lw_data = 8'h00;
    logic [2:0] wr_shape = 3'b000;
    logic [7:0] wr_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sio_rd && sio_wr) both_err <= both_err + 1;
        if (sio_ce && sio_rd && sio_cd) begin
            stat_n        <= stat_n + 1;
            last_period   <= cyc - last_stat_cyc;
            last_stat_cyc <= cyc;
        end
        if (sio_ce && sio_rd && !sio_cd) begin
            rd_n    <= rd_n + 1;
            rd_gap  <= cyc - last_stat_cyc;
            rd_stat <= stat_n;
        end
        if (sio_wr) begin
            wr_n     <= wr_n + 1;
            wr_gap   <= cyc - last_stat_cyc;
            wr_stat  <= stat_n;
            lw_data  <= sio_dout;
            wr_shape <= {sio_ce, sio_rd, sio_cd};
            wr_data_q.push_back(sio_dout);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic wait_stat(input int lim, output bit ok);
        int s0;
        s0 = stat_n;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if (stat_n != s0) ok = 1'b1;
        end
    endtask

    task automatic push_tx(input logic [7:0] b, output logic acc);
        @(negedge clk); #1;
        tx_data = b; tx_valid = 1'b1; acc = tx_ready;
        @(negedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; m_txidle = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if ({sio_ce, sio_rd, sio_wr, sio_cd} !== 4'b0000) $display("FAIL rst_strobes got %b exp 0000", {sio_ce, sio_rd, sio_wr, sio_cd}); else n_pass++;
        n_chk++; if (sio_dout !== 8'h00) $display("FAIL rst_dout got %h exp 00", sio_dout); else n_pass++;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready got %b exp 0", tx_ready); else n_pass++;
        rst = 1'b0; #1;
        n_chk++; if ({sio_ce, sio_rd, sio_wr, sio_cd, rx_valid, tx_ready} !== 6'b000001)
            $display("FAIL release_state got %b exp 000001", {sio_ce, sio_rd, sio_wr, sio_cd, rx_valid, tx_ready}); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if ({sio_ce, sio_rd, sio_wr, sio_cd} !== 4'b1101) $display("FAIL first_stat got %b exp 1101", {sio_ce, sio_rd, sio_wr, sio_cd}); else n_pass++;
    endtask

    task automatic test_tx();
        logic acc;
        int   w0;
        bit   ok;
        push_tx(8'hA5, acc);
        n_chk++; if (acc !== 1'b1) $display("FAIL tx_push_acc got %b exp 1", acc); else n_pass++;
        w0 = wr_n; m_txidle = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); #1; if (wr_n != w0) ok = 1'b1; end
        n_chk++; if (!ok) $display("FAIL tx_write_seen got timeout exp write"); else n_pass++;
        n_chk++; if (lw_data !== 8'hA5) $display("FAIL tx_dout got %h exp a5", lw_data); else n_pass++;
        n_chk++; if (wr_gap !== 2) $display("FAIL tx_latency got %0d exp 2", wr_gap); else n_pass++;
        n_chk++; if (wr_shape !== 3'b100) $display("FAIL tx_shape ce,rd,cd got %b exp 100", wr_shape); else n_pass++;
        wait_stat(10, ok);
        n_chk++; if (!ok || last_period !== 4) $display("FAIL tx_loop_len got %0d exp 4", last_period); else n_pass++;
        repeat (12) @(negedge clk); #1;
        n_chk++; if (wr_n !== w0 + 1) $display("FAIL tx_single_write got %0d exp %0d", wr_n - w0, 1); else n_pass++;
        n_chk++; if (last_period !== 3) $display("FAIL idle_loop_len got %0d exp 3", last_period); else n_pass++;
        m_txidle = 1'b0;
    endtask

    task automatic test_rx();
        bit ok;
        rxq.push_back(8'h3C); ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); #1; if (rx_valid) ok = 1'b1; end
        n_chk++; if (!ok) $display("FAIL rx_valid_seen got timeout exp valid"); else n_pass++;
        n_chk++; if (cyc - last_stat_cyc !== 4) $display("FAIL rx_latency got %0d exp 4", cyc - last_stat_cyc); else n_pass++;
        n_chk++; if (rd_gap !== 2) $display("FAIL rx_read_delay got %0d exp 2", rd_gap); else n_pass++;
        n_chk++; if (rx_data !== 8'h3C) $display("FAIL rx_data got %h exp 3c", rx_data); else n_pass++;
        wait_stat(10, ok);
        n_chk++; if (!ok || last_period !== 5) $display("FAIL rx_loop_len got %0d exp 5", last_period); else n_pass++;
        repeat (6) @(negedge clk); #1;
        n_chk++; if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) $display("FAIL rx_hold got %b/%h exp 1/3c", rx_valid, rx_data); else n_pass++;
        rx_ready = 1'b1;
        @(negedge clk); #1;
        rx_ready = 1'b0;
        n_chk++; if (rx_valid !== 1'b0) $display("FAIL rx_pop_empty got %b exp 0", rx_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        int         r0, s0;
        bit         ok;
        logic [7:0] exp_b;
        for (int i = 1; i <= 5; i++) rxq.push_back(8'(i));
        r0 = rd_n;
        repeat (40) @(negedge clk); #1;
        n_chk++; if (rd_n - r0 !== 4) $display("FAIL bp_reads got %0d exp 4", rd_n - r0); else n_pass++;
        n_chk++; if (rxq.size() !== 1) $display("FAIL bp_left_in_periph got %0d exp 1", rxq.size()); else n_pass++;
        n_chk++; if ({rx_valid, rx_data} !== {1'b1, 8'h01}) $display("FAIL bp_head got %b/%h exp 1/01", rx_valid, rx_data); else n_pass++;
        s0 = stat_n;
        repeat (10) @(negedge clk); #1;
        n_chk++; if (stat_n - s0 < 2) $display("FAIL bp_polling got %0d exp >=2", stat_n - s0); else n_pass++;
        n_chk++; if (rd_n - r0 !== 4) $display("FAIL bp_no_read got %0d exp 4", rd_n - r0); else n_pass++;
        rx_ready = 1'b1;
        @(negedge clk); #1;
        rx_ready = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); #1; if (rd_n - r0 == 5) ok = 1'b1; end
        n_chk++; if (!ok) $display("FAIL bp_fifth_read got timeout exp read"); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            exp_b = 8'(k + 2);
            n_chk++; if ({rx_valid, rx_data} !== {1'b1, exp_b}) $display("FAIL bp_order got %b/%h exp 1/%h", rx_valid, rx_data, exp_b); else n_pass++;
            rx_ready = 1'b1;
            @(negedge clk); #1;
            rx_ready = 1'b0;
        end
        n_chk++; if (rx_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", rx_valid); else n_pass++;
    endtask

    task automatic test_priority();
        logic acc;
        int   r0, w0;
        bit   ok;
        push_tx(8'h77, acc);
        n_chk++; if (acc !== 1'b1) $display("FAIL prio_push got %b exp 1", acc); else n_pass++;
        r0 = rd_n; w0 = wr_n;
        rxq.push_back(8'h5A); m_txidle = 1'b1; ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); #1; if (wr_n != w0) ok = 1'b1; end
        n_chk++; if (!ok) $display("FAIL prio_write_seen got timeout exp write"); else n_pass++;
        n_chk++; if (rd_n - r0 !== 1) $display("FAIL prio_reads got %0d exp 1", rd_n - r0); else n_pass++;
        n_chk++; if (wr_stat !== rd_stat + 1) $display("FAIL prio_order got poll %0d exp %0d", wr_stat, rd_stat + 1); else n_pass++;
        n_chk++; if (lw_data !== 8'h77) $display("FAIL prio_wdata got %h exp 77", lw_data); else n_pass++;
        m_txidle = 1'b0;
        n_chk++; if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) $display("FAIL prio_rdata got %b/%h exp 1/5a", rx_valid, rx_data); else n_pass++;
        rx_ready = 1'b1;
        @(negedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_tx_full();
        logic [4:0] acc_v;
        logic [7:0] exp_w [5];
        int         w0;
        bit         ok;
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h88};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            tx_data = 8'((i + 1) * 17); tx_valid = 1'b1; acc_v[i] = tx_ready;
        end
        @(negedge clk); #1;
        tx_valid = 1'b0;
        n_chk++; if (acc_v !== 5'b01111) $display("FAIL full_accept got %b exp 01111", acc_v); else n_pass++;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", tx_ready); else n_pass++;
        w0 = wr_n;
        // Raise tx idle inside a status strobe so the write lands 2 cycles later.
        wait_stat(20, ok);
        m_txidle = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_chk++; if (!ok || {sio_ce, sio_wr, sio_cd} !== 3'b110) $display("FAIL full_wr1_strobe got %b exp 110", {sio_ce, sio_wr, sio_cd}); else n_pass++;
        tx_data = 8'h66; tx_valid = 1'b1;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL full_push_on_pop got %b exp 0", tx_ready); else n_pass++;
        @(negedge clk); #1;
        tx_valid = 1'b0;
        wait_stat(20, ok);
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_chk++; if (!ok || {sio_ce, sio_wr, sio_cd} !== 3'b110) $display("FAIL full_wr2_strobe got %b exp 110", {sio_ce, sio_wr, sio_cd}); else n_pass++;
        tx_data = 8'h88; tx_valid = 1'b1;
        n_chk++; if (tx_ready !== 1'b1) $display("FAIL notfull_push_on_pop got %b exp 1", tx_ready); else n_pass++;
        @(negedge clk); #1;
        tx_valid = 1'b0; ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); #1; if (wr_n - w0 >= 5) ok = 1'b1; end
        n_chk++; if (!ok) $display("FAIL full_writes got %0d exp 5", wr_n - w0); else n_pass++;
        for (int k = 0; k < 5 && ok; k++) begin
            n_chk++; if (wr_data_q[w0 + k] !== exp_w[k]) $display("FAIL full_order[%0d] got %h exp %h", k, wr_data_q[w0 + k], exp_w[k]); else n_pass++;
        end
        repeat (12) @(negedge clk); #1;
        n_chk++; if (wr_n - w0 !== 5) $display("FAIL full_no_extra got %0d exp 5", wr_n - w0); else n_pass++;
        m_txidle = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic acc;
        int   w0;
        bit   ok;
        push_tx(8'h99, acc);
        wait_stat(20, ok);
        rst = 1'b1;
        @(negedge clk); #1;
        n_chk++; if (!ok || {sio_ce, sio_rd, sio_wr, sio_cd} !== 4'b0000) $display("FAIL mid_rst_abort got %b exp 0000", {sio_ce, sio_rd, sio_wr, sio_cd}); else n_pass++;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL mid_rst_ready got %b exp 0", tx_ready); else n_pass++;
        @(negedge clk); #1;
        rst = 1'b0; #1;
        n_chk++; if ({rx_valid, tx_ready} !== 2'b01) $display("FAIL mid_release got %b exp 01", {rx_valid, tx_ready}); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if ({sio_ce, sio_rd, sio_wr, sio_cd} !== 4'b1101) $display("FAIL mid_first_stat got %b exp 1101", {sio_ce, sio_rd, sio_wr, sio_cd}); else n_pass++;
        w0 = wr_n; m_txidle = 1'b1;
        repeat (15) @(negedge clk); #1;
        n_chk++; if (wr_n !== w0) $display("FAIL mid_fifo_cleared got %0d writes exp 0", wr_n - w0); else n_pass++;
        m_txidle = 1'b0;
    endtask

    task automatic test_final();
        n_chk++; if (both_err !== 0) $display("FAIL rd_wr_exclusive got %0d overlaps exp 0", both_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_backpressure();
        test_priority();
        test_tx_full();
        test_reset_mid();
        test_final();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
